// File: rtl/binario_a_bcd_pkg.sv
// -----------------------------------------------------------------------------
// binario_bcd_pkg
// Shared definitions for the binary-to-BCD converter:
//   - state_t     : converter FSM states (IDLE, CONV)
//   - N_ITER      : shift/add-3 iterations, one per operand bit
//   - BCD_W/N_DIG : digit width and number of BCD digits produced
//   - ADD3_THRESH : nibble value from which the +3 correction applies
// -----------------------------------------------------------------------------
package binario_bcd_pkg;

  localparam int DATA_W = 8;
  localparam int N_ITER = 8;
  localparam int IT_W   = $clog2(N_ITER);
  localparam int BCD_W  = 4;
  localparam int N_DIG  = 3;
  localparam int ACC_W  = BCD_W * N_DIG;

  localparam logic [BCD_W-1:0] ADD3_THRESH = 4'd5;
  localparam logic [BCD_W-1:0] ADD3_VAL    = 4'd3;

  // Counter value at which the last iteration is executed.
  localparam logic [IT_W-1:0] IT_LAST = IT_W'(N_ITER - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

endpackage

// File: rtl/binario_a_bcd_if.sv
// -----------------------------------------------------------------------------
// binario_a_bcd_if
// Request/result bundle between the product source and the converter.
//   start, valor              : request side (driven by master)
//   busy, done                : status (driven by slave)
//   signo, centenas, decenas,
//   unidades                  : held conversion result (driven by slave)
//
// Handshake: a request is accepted on a rising edge where start=1 and
// busy=0; valor is sampled on that same edge only. start while busy=1 is
// dropped, not queued. done is a one-cycle pulse marking the edge where the
// result registers were updated; the result holds until the next done.
// -----------------------------------------------------------------------------
interface binario_a_bcd_if;
  import binario_bcd_pkg::*;

  logic                 start;
  logic [DATA_W-1:0]    valor;
  logic                 busy;
  logic                 done;
  logic                 signo;
  logic [BCD_W-1:0]     unidades;
  logic [BCD_W-1:0]     decenas;
  logic [BCD_W-1:0]     centenas;

  modport master (
    output start, valor,
    input  busy, done, signo, unidades, decenas, centenas
  );

  modport slave (
    input  start, valor,
    output busy, done, signo, unidades, decenas, centenas
  );

endinterface

// File: rtl/binario_a_bcd_suma3.sv
// -----------------------------------------------------------------------------
// suma3_bcd
// Combinational add-3 corrector for one BCD nibble of the shift-and-add-3
// algorithm: a nibble of 5 or more becomes 8 or more after +3, so the
// following left shift carries into the next digit exactly when the digit
// would have exceeded 9.
//   i_nib : current BCD nibble
//   o_nib : corrected nibble (i_nib + 3 when i_nib >= 5)
// -----------------------------------------------------------------------------
module suma3_bcd
  import binario_bcd_pkg::*;
(
  input  logic [BCD_W-1:0] i_nib,
  output logic [BCD_W-1:0] o_nib
);

  assign o_nib = (i_nib >= ADD3_THRESH) ? (i_nib + ADD3_VAL) : i_nib;

endmodule

// File: rtl/binario_a_bcd.sv
// -----------------------------------------------------------------------------
// binario_a_bcd
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Converts the 8-bit product into hundreds/tens/units plus a sign flag and
// holds the digits stable between conversions for the display multiplexer.
//
// Parameters:
//   SIGNED      : 1 = valor is two's complement (signo/magnitude produced),
//                 0 = valor is unsigned (signo stays 0)
// Ports:
//   clk         : system clock, rising edge
//   rst         : asynchronous, active-high reset
//   bus         : slave side of binario_a_bcd_if (start/valor in,
//                 busy/done/signo/digits out)
//   o_dbg_state : current FSM state
// -----------------------------------------------------------------------------
module binario_a_bcd
  import binario_bcd_pkg::*;
#(
  parameter bit SIGNED = 1'b1
)
(
  input  logic            clk,
  input  logic            rst,
  binario_a_bcd_if.slave  bus,
  output state_t          o_dbg_state
);

  // FSM
  state_t r_state;
  state_t w_state_next;
  logic   w_load;
  logic   w_step;
  logic   w_finish;

  // Datapath
  logic [IT_W-1:0]   r_it;
  logic [DATA_W-1:0] r_sh;
  logic [ACC_W-1:0]  r_acc;
  logic              r_signo_pend;

  // Output registers
  logic              r_done;
  logic              r_signo;
  logic [BCD_W-1:0]  r_uni;
  logic [BCD_W-1:0]  r_dec;
  logic [BCD_W-1:0]  r_cen;

  // Combinational helpers
  logic              w_neg;
  logic [DATA_W-1:0] w_mag;
  logic [ACC_W-1:0]  w_acc_adj;
  logic [ACC_W-1:0]  w_acc_shift;
  logic [DATA_W-1:0] w_sh_shift;

  // ---------------------------------------------------------------------------
  // Operand conditioning. In signed mode the magnitude of -128 is 128, which
  // still fits the 8-bit shift register when read as unsigned. Zero has
  // bit 7 clear, so it is never flagged negative.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_neg = SIGNED && bus.valor[DATA_W-1];
    w_mag = w_neg ? ((~bus.valor) + 8'd1) : bus.valor;
  end

  // ---------------------------------------------------------------------------
  // Add-3 correction on every digit, then one left shift of {acc, sh}.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < N_DIG; g++) begin : g_suma3
    suma3_bcd u_suma3 (
      .i_nib (r_acc[g*BCD_W +: BCD_W]),
      .o_nib (w_acc_adj[g*BCD_W +: BCD_W])
    );
  end

  always_comb begin
    {w_acc_shift, w_sh_shift} = {w_acc_adj, r_sh} << 1;
  end

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_load       = 1'b1;
          w_state_next = CONV;
        end
      end
      CONV: begin
        w_step = 1'b1;
        if (r_it == IT_LAST) begin
          w_finish     = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shift registers, iteration counter and held result. The result registers
  // load straight from the shifted value of the last iteration, so they move
  // only on the completion edge and never show a partial conversion.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_it         <= '0;
      r_sh         <= '0;
      r_acc        <= '0;
      r_signo_pend <= 1'b0;
      r_done       <= 1'b0;
      r_signo      <= 1'b0;
      r_uni        <= '0;
      r_dec        <= '0;
      r_cen        <= '0;
    end else begin
      r_done <= w_finish;
      if (w_load) begin
        r_sh         <= w_mag;
        r_acc        <= '0;
        r_it         <= '0;
        r_signo_pend <= w_neg;
      end else if (w_step) begin
        r_sh  <= w_sh_shift;
        r_acc <= w_acc_shift;
        r_it  <= r_it + 1'b1;
      end
      if (w_finish) begin
        r_uni   <= w_acc_shift[0*BCD_W +: BCD_W];
        r_dec   <= w_acc_shift[1*BCD_W +: BCD_W];
        r_cen   <= w_acc_shift[2*BCD_W +: BCD_W];
        r_signo <= r_signo_pend;
      end
    end
  end

  assign bus.busy     = (r_state == CONV);
  assign bus.done     = r_done;
  assign bus.signo    = r_signo;
  assign bus.unidades = r_uni;
  assign bus.decenas  = r_dec;
  assign bus.centenas = r_cen;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_binario_a_bcd.sv
module tb_binario_a_bcd;
  import binario_bcd_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  binario_a_bcd_if bus_u ();
  binario_a_bcd_if bus_s ();
  state_t dbg_u;
  state_t dbg_s;

  binario_a_bcd #(.SIGNED(1'b0)) dut_u (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_u.slave),
    .o_dbg_state (dbg_u)
  );

  binario_a_bcd #(.SIGNED(1'b1)) dut_s (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_s.slave),
    .o_dbg_state (dbg_s)
  );

  // Index 0 = unsigned DUT, index 1 = signed DUT.
  logic [1:0]  obs_done;
  logic [1:0]  obs_busy;
  logic [12:0] obs_res [2];
  assign obs_done   = {bus_s.done, bus_u.done};
  assign obs_busy   = {bus_s.busy, bus_u.busy};
  assign obs_res[0] = {bus_u.signo, bus_u.centenas, bus_u.decenas, bus_u.unidades};
  assign obs_res[1] = {bus_s.signo, bus_s.centenas, bus_s.decenas, bus_s.unidades};

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          n_checks = 0;
  int          n_errors = 0;
  int          done_cnt [2] = '{0, 0};
  int          exp_done [2] = '{0, 0};
  logic [12:0] last_res [2];
  logic [12:0] exp_q_u [$];
  logic [12:0] exp_q_s [$];

  always @(negedge clk) begin
    if (bus_u.done) done_cnt[0]++;
    if (bus_s.done) done_cnt[1]++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: sign/magnitude by plain arithmetic, digits by div/mod.
  function automatic logic [12:0] model(input int v, input bit signed_mode);
    bit neg;
    int mag;
    neg = signed_mode && (v >= 128);
    mag = neg ? (256 - v) : v;
    return {neg, 4'(mag / 100), 4'((mag / 10) % 10), 4'(mag % 10)};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive_start(input bit use_u, input bit use_s, input logic [7:0] v);
    if (use_u) begin bus_u.start = 1'b1; bus_u.valor = v; exp_done[0]++; end
    if (use_s) begin bus_s.start = 1'b1; bus_s.valor = v; exp_done[1]++; end
    @(posedge clk);
    #1;
    bus_u.start = 1'b0;
    bus_s.start = 1'b0;
    bus_u.valor = 8'($urandom);
    bus_s.valor = 8'($urandom);
  endtask

  // Waits for done on one DUT; lat is the number of negedges before done,
  // counting the one right after the accepting edge as 0.
  task automatic wait_done(input int sel, input string tag,
                           output int lat, output int busy_n, output bit held_ok);
    lat     = -1;
    busy_n  = 0;
    held_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (obs_done[sel]) begin
        lat = i;
        break;
      end
      if (obs_busy[sel]) busy_n++;
      if (obs_res[0] !== last_res[0] || obs_res[1] !== last_res[1]) held_ok = 1'b0;
    end
    check({tag, "_seen"}, 32'(lat >= 0), 1);
  endtask

  task automatic check_done_counts(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_done_u"}, done_cnt[0], exp_done[0]);
    check({tag, "_done_s"}, done_cnt[1], exp_done[1]);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [7:0]  sv_vals [3] = '{8'h80, 8'hFF, 8'h00};
  logic [12:0] sv_exp  [3] = '{13'h1128, 13'h1001, 13'h0000};
  int          order   [256];

  initial begin
    int lat;
    int busy_n;
    bit held_ok;
    logic [12:0] e;

    rst = 1'b1;
    bus_u.start = 1'b0; bus_u.valor = '0;
    bus_s.start = 1'b0; bus_s.valor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (10) @(negedge clk);

    // Reset then idle
    check("rst_res_u", obs_res[0], 0);
    check("rst_res_s", obs_res[1], 0);
    check("rst_busy", obs_busy, 0);
    check("rst_done", obs_done, 0);
    check("rst_state_u", dbg_u, IDLE);
    check("rst_state_s", dbg_s, IDLE);
    check_done_counts("idle");
    last_res[0] = '0;
    last_res[1] = '0;

    // Unsigned 255
    @(negedge clk);
    drive_start(1'b1, 1'b0, 8'd255);
    wait_done(0, "u255", lat, busy_n, held_ok);
    check("u255_lat", lat, 8);
    check("u255_busy_cycles", busy_n, 8);
    check("u255_held", held_ok, 1);
    check("u255_res", obs_res[0], 13'h0255);
    check("u255_busy_at_done", obs_busy[0], 0);
    last_res[0] = 13'h0255;
    @(negedge clk);
    check("u255_done_width", obs_done[0], 0);
    check("u255_res_hold", obs_res[0], 13'h0255);

    // Signed directed values
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_start(1'b0, 1'b1, sv_vals[i]);
      wait_done(1, $sformatf("s_%0h", sv_vals[i]), lat, busy_n, held_ok);
      check($sformatf("s_%0h_lat", sv_vals[i]), lat, 8);
      check($sformatf("s_%0h_held", sv_vals[i]), held_ok, 1);
      check($sformatf("s_%0h_res", sv_vals[i]), obs_res[1], sv_exp[i]);
      last_res[1] = sv_exp[i];
    end

    // Busy protection: second start at E0+3 is dropped
    @(negedge clk);
    drive_start(1'b0, 1'b1, 8'd99);
    repeat (3) @(negedge clk);
    bus_s.start = 1'b1;
    bus_s.valor = 8'd42;
    @(posedge clk);
    #1;
    bus_s.start = 1'b0;
    wait_done(1, "busy99", lat, busy_n, held_ok);
    check("busy99_res", obs_res[1], 13'h0099);
    last_res[1] = 13'h0099;

    // Start in the done cycle is accepted
    drive_start(1'b0, 1'b1, 8'd42);
    wait_done(1, "b2b42", lat, busy_n, held_ok);
    check("b2b42_lat", lat, 8);
    check("b2b42_held", held_ok, 1);
    check("b2b42_res", obs_res[1], 13'h0042);
    last_res[1] = 13'h0042;
    check_done_counts("busy");

    // Abort with reset at E0+4
    @(negedge clk);
    drive_start(1'b0, 1'b1, 8'd123);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_done[1]--;
    #1;
    check("abort_res_s", obs_res[1], 0);
    check("abort_res_u", obs_res[0], 0);
    check("abort_busy", obs_busy, 0);
    check("abort_done", obs_done, 0);
    check("abort_state", dbg_s, IDLE);
    last_res[0] = '0;
    last_res[1] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_idle_busy", obs_busy, 0);
    check("abort_idle_res", obs_res[1], 0);
    check_done_counts("abort");
    @(negedge clk);
    drive_start(1'b0, 1'b1, 8'd7);
    wait_done(1, "after7", lat, busy_n, held_ok);
    check("after7_lat", lat, 8);
    check("after7_res", obs_res[1], 13'h0007);
    last_res[1] = 13'h0007;

    // Exhaustive sweep in shuffled order, both modes side by side
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j;
      int t;
      j = int'($urandom_range(i, 0));
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      int v;
      v = order[i];
      repeat ($urandom_range(2, 0)) @(negedge clk);
      @(negedge clk);
      exp_q_u.push_back(model(v, 1'b0));
      exp_q_s.push_back(model(v, 1'b1));
      drive_start(1'b1, 1'b1, 8'(v));
      wait_done(1, $sformatf("sw_%0d", v), lat, busy_n, held_ok);
      check($sformatf("sw_%0d_lat", v), lat, 8);
      check($sformatf("sw_%0d_done_u", v), obs_done[0], 1);
      check($sformatf("sw_%0d_held", v), held_ok, 1);
      e = exp_q_u.pop_front();
      check($sformatf("sw_%0d_res_u", v), obs_res[0], e);
      last_res[0] = e;
      e = exp_q_s.pop_front();
      check($sformatf("sw_%0d_res_s", v), obs_res[1], e);
      last_res[1] = e;
    end
    check_done_counts("sweep");
    check("q_empty_u", exp_q_u.size(), 0);
    check("q_empty_s", exp_q_s.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
